encap_result_streamer: RTL and testbench

- Reads the encapsulation results out of encap_seq_gen after its done pulse: ciphertext C0, then C1, then session key K.
- Drives the rd_C0/C0_addr, rd_C1/C1_addr and rd_K/K_addr read ports.
- Presents the words as a single 32-bit valid/ready stream toward the host/UART side.
- Carries the data in the opposite direction to the seed loader and replaces the testbench $writememb dumps in hardware builds.

---
 rtl/encap_result_streamer.sv | 212 +++++++++++++++++++++
 tb/tb_encap_result_streamer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encap_result_streamer.sv
// encap_result_streamer: after encap_seq_gen finishes, this block reads out
// C0, then C1, then the session key K. It sends those words to the host
// side as a single 32-bit valid/ready stream with a source tag and a
// last-word flag.
module encap_result_streamer #(
  parameter int parameter_set = 1,
  parameter int m             = (parameter_set == 1) ? 12 : 13,
  parameter int t             = (parameter_set == 1) ? 64 :
                                (parameter_set == 2) ? 96 :
                                (parameter_set == 4) ? 119 : 128,
  parameter int l             = m * t,
  parameter int C0_WORDS      = (l + 31) / 32,
  parameter int C1_WORDS      = 8,
  parameter int K_WORDS       = 8,
  parameter int C0_AW         = (C0_WORDS > 1) ? $clog2(C0_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_C0,
  output logic [C0_AW-1:0] C0_addr,
  input  logic [31:0]      C0_out,
  output logic             rd_C1,
  output logic [2:0]       C1_addr,
  input  logic [31:0]      C1_out,
  output logic             rd_K,
  output logic [2:0]       K_addr,
  input  logic [31:0]      K_out,
  output logic [31:0]      dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [1:0]       dout_sel,
  output logic             dout_last
);

  typedef enum logic [2:0] {IDLE, RD_C0, RD_C1, RD_K, DRAIN} state_t;
  typedef enum logic [1:0] {SEL_C0 = 2'd0, SEL_C1 = 2'd1, SEL_K = 2'd2} sel_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  sel;
    logic        last;
  } entry_t;

  // When C0 does not fill its last word, the unused upper bits are zeroed.
  localparam int          PAD_BITS  = l % 32;
  localparam logic [31:0] LAST_MASK = (PAD_BITS == 0) ? 32'hFFFF_FFFF
                                    : ((32'd1 << PAD_BITS) - 32'd1);

  state_t     state, state_nxt;
  logic       done_nxt;

  // Two-entry output FIFO. The head register drives dout directly.
  entry_t     head_q, tail_q;
  logic [1:0] fifo_cnt;

  // Describes the single read whose data returns on the next cycle.
  logic       infl_v;
  sel_t       infl_sel;
  logic       infl_pad;
  logic       infl_last;

  logic       pop, push;
  logic [2:0] occ_after;
  logic       issue_ok;
  logic       c0_end, c1_end, k_end;
  entry_t     push_entry;

  assign pop        = dout_valid && dout_ready;
  assign push       = infl_v;
  assign dout_valid = (fifo_cnt != 2'd0);
  assign dout       = head_q.data;
  assign dout_sel   = head_q.sel;
  assign dout_last  = head_q.last;
  assign busy       = (state != IDLE);

  // Count a word leaving this cycle as already gone. With the sink always
  // ready, this lets a new read issue every cycle while the FIFO and the
  // pending read together never hold more than two words.
  assign occ_after = {1'b0, fifo_cnt} + {2'b0, infl_v} - {2'b0, pop};
  assign issue_ok  = (occ_after < 3'd2);

  assign c0_end = (C0_addr == C0_AW'(C0_WORDS - 1));
  assign c1_end = (C1_addr == 3'(C1_WORDS - 1));
  assign k_end  = (K_addr  == 3'(K_WORDS - 1));

  // State register and registered done pulse.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the clock edge, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state logic and read strobes. A read issues only while its own
  // section is active and the FIFO has room.
  always_comb begin
    // NOTE: give every output a default first, so no path through the case
    // leaves a signal unassigned and creates a latch.
    state_nxt = state;
    done_nxt  = 1'b0;
    rd_C0     = 1'b0;
    rd_C1     = 1'b0;
    rd_K      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RD_C0;
      RD_C0: if (issue_ok) begin
        rd_C0 = 1'b1;
        if (c0_end) state_nxt = RD_C1;
      end
      RD_C1: if (issue_ok) begin
        rd_C1 = 1'b1;
        if (c1_end) state_nxt = RD_K;
      end
      RD_K: if (issue_ok) begin
        rd_K = 1'b1;
        if (k_end) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Assert done on the same edge that hands off the final word.
        if (!infl_v && (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && pop))) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read addresses restart at 0 on an accepted start. Each address stops
  // at its section's last word and keeps that value until the next start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      C0_addr <= '0;
      C1_addr <= '0;
      K_addr  <= '0;
    end else if (state == IDLE && start) begin
      C0_addr <= '0;
      C1_addr <= '0;
      K_addr  <= '0;
    end else begin
      if (rd_C0 && !c0_end) C0_addr <= C0_addr + 1'b1;
      if (rd_C1 && !c1_end) C1_addr <= C1_addr + 1'b1;
      if (rd_K  && !k_end)  K_addr  <= K_addr + 1'b1;
    end
  end

  // Record the source, padding need and last flag of each read issued, so
  // the returning data can be tagged on the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      infl_v    <= 1'b0;
      infl_sel  <= SEL_C0;
      infl_pad  <= 1'b0;
      infl_last <= 1'b0;
    end else begin
      infl_v    <= rd_C0 || rd_C1 || rd_K;
      infl_sel  <= rd_C0 ? SEL_C0 : (rd_C1 ? SEL_C1 : SEL_K);
      infl_pad  <= rd_C0 && c0_end;
      infl_last <= rd_K && k_end;
    end
  end

  // Choose the returning read data, then zero the padding bits of the
  // final C0 word.
  always_comb begin
    push_entry      = '0;
    push_entry.sel  = infl_sel;
    push_entry.last = infl_last;
    unique case (infl_sel)
      SEL_C0:  push_entry.data = C0_out;
      SEL_C1:  push_entry.data = C1_out;
      default: push_entry.data = K_out;
    endcase
    if (infl_pad) push_entry.data = push_entry.data & LAST_MASK;
  end

  // Output FIFO. Push and pop may occur on the same edge. The head register
  // changes only when a word is popped or when the FIFO is empty, so dout
  // holds steady during a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: these two entries are registers, not RAM. They are reset so
      // dout, dout_sel and dout_last read 0 after reset.
      fifo_cnt <= 2'd0;
      head_q   <= '0;
      tail_q   <= '0;
    end else if (push && pop) begin
      if (fifo_cnt == 2'd2) begin
        head_q <= tail_q;
        tail_q <= push_entry;
      end else begin
        head_q <= push_entry;
      end
    end else if (push) begin
      if (fifo_cnt == 2'd0) head_q <= push_entry;
      else                  tail_q <= push_entry;
      fifo_cnt <= fifo_cnt + 2'd1;
    end else if (pop) begin
      if (fifo_cnt == 2'd2) head_q <= tail_q;
      fifo_cnt <= fifo_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_encap_result_streamer.sv
// Testbench for encap_result_streamer. Two instances are used: parameter
// set 1 (24 C0 words) and set 4 (49 C0 words, last C0 word padded). Each
// stream is compared with an expected word list built directly from the
// memory contents.
module tb_encap_result_streamer;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  sel;
    logic        last;
  } word_t;

  logic clk, rst;
  int   cyc;
  int   checks, errors;

  // Instance A signals (parameter set 1).
  logic        a_start, a_busy, a_done;
  logic        a_rd_C0, a_rd_C1, a_rd_K;
  logic [4:0]  a_C0_addr;
  logic [2:0]  a_C1_addr, a_K_addr;
  logic [31:0] a_C0_out, a_C1_out, a_K_out;
  logic [31:0] a_dout;
  logic        a_dout_valid, a_dout_ready, a_dout_last;
  logic [1:0]  a_dout_sel;

  // Instance B signals (parameter set 4).
  logic        b_start, b_busy, b_done;
  logic        b_rd_C0, b_rd_C1, b_rd_K;
  logic [5:0]  b_C0_addr;
  logic [2:0]  b_C1_addr, b_K_addr;
  logic [31:0] b_C0_out, b_C1_out, b_K_out;
  logic [31:0] b_dout;
  logic        b_dout_valid, b_dout_ready, b_dout_last;
  logic [1:0]  b_dout_sel;

  logic [31:0] a_c0_mem [24];
  logic [31:0] a_c1_mem [8];
  logic [31:0] a_k_mem  [8];
  logic [31:0] b_c0_mem [49];
  logic [31:0] b_c1_mem [8];
  logic [31:0] b_k_mem  [8];

  word_t a_got[$], b_got[$], exp_q[$];

  // Monitor state.
  int    a_done_cnt, a_done_cyc, a_start_cyc;
  int    b_done_cnt, b_done_cyc, b_start_cyc;
  int    a_stall_cnt, a_stable_viol, a_onehot_viol, a_max_out;
  int    a_iss, a_acc;
  logic  a_prev_stall;
  word_t a_prev_word, a_cur;
  logic  a_pop, a_rd;
  int    a_mode;   // 0: ready always 1, 1: ready 1,0,0,1 repeating, 2: random
  int    a_phase;

  encap_result_streamer #(.parameter_set(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .rd_C0(a_rd_C0), .C0_addr(a_C0_addr), .C0_out(a_C0_out),
    .rd_C1(a_rd_C1), .C1_addr(a_C1_addr), .C1_out(a_C1_out),
    .rd_K(a_rd_K), .K_addr(a_K_addr), .K_out(a_K_out),
    .dout(a_dout), .dout_valid(a_dout_valid), .dout_ready(a_dout_ready),
    .dout_sel(a_dout_sel), .dout_last(a_dout_last)
  );

  encap_result_streamer #(.parameter_set(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_C0(b_rd_C0), .C0_addr(b_C0_addr), .C0_out(b_C0_out),
    .rd_C1(b_rd_C1), .C1_addr(b_C1_addr), .C1_out(b_C1_out),
    .rd_K(b_rd_K), .K_addr(b_K_addr), .K_out(b_K_out),
    .dout(b_dout), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready),
    .dout_sel(b_dout_sel), .dout_last(b_dout_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memories with one-cycle read latency.
  always @(posedge clk) begin
    if (a_rd_C0) a_C0_out <= a_c0_mem[a_C0_addr];
    if (a_rd_C1) a_C1_out <= a_c1_mem[a_C1_addr];
    if (a_rd_K)  a_K_out  <= a_k_mem[a_K_addr];
    if (b_rd_C0) b_C0_out <= b_c0_mem[b_C0_addr];
    if (b_rd_C1) b_C1_out <= b_c1_mem[b_C1_addr];
    if (b_rd_K)  b_K_out  <= b_k_mem[b_K_addr];
  end

  // Drive the sink-ready input of instance A just after each rising edge.
  initial begin
    a_dout_ready = 1'b1;
    a_phase      = 0;
    forever begin
      @(posedge clk);
      #1;
      case (a_mode)
        1:       a_dout_ready = (a_phase % 4 == 0) || (a_phase % 4 == 3);
        2:       a_dout_ready = 1'($urandom_range(0, 1));
        default: a_dout_ready = 1'b1;
      endcase
      a_phase++;
    end
  end

  // Instance A monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      a_prev_stall = 1'b0;
      a_iss        = 0;
      a_acc        = 0;
    end else begin
      a_cur = {a_dout, a_dout_sel, a_dout_last};
      a_pop = a_dout_valid && a_dout_ready;
      a_rd  = a_rd_C0 || a_rd_C1 || a_rd_K;
      if (a_prev_stall) begin
        a_stall_cnt++;
        if (!a_dout_valid || a_cur != a_prev_word) a_stable_viol++;
      end
      if (a_pop) a_got.push_back(a_cur);
      if (a_iss + int'(a_rd) - a_acc - int'(a_pop) > a_max_out)
        a_max_out = a_iss + int'(a_rd) - a_acc - int'(a_pop);
      a_iss += int'(a_rd);
      a_acc += int'(a_pop);
      if ($countones({a_rd_C0, a_rd_C1, a_rd_K}) > 1) a_onehot_viol++;
      if (a_done) begin
        a_done_cnt++;
        a_done_cyc = cyc;
      end
      a_prev_stall = a_dout_valid && !a_dout_ready;
      a_prev_word  = a_cur;
    end
  end

  // Instance B monitor.
  always @(negedge clk) begin
    if (rst) begin
      if (b_dout_valid && b_dout_ready) b_got.push_back({b_dout, b_dout_sel, b_dout_last});
      if (b_done) begin
        b_done_cnt++;
        b_done_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: C0 length is m*t bits, rounded up to whole words.
  // Unused upper bits of the last C0 word are zero. C1 (8 words) follows,
  // then K (8 words), and the final K word is marked last.
  function automatic int c0_bits(input int set);
    int mm, tt;
    mm = (set == 1) ? 12 : 13;
    case (set)
      1:       tt = 64;
      2:       tt = 96;
      4:       tt = 119;
      default: tt = 128;
    endcase
    return mm * tt;
  endfunction

  function automatic int c0_words(input int set);
    return (c0_bits(set) + 31) / 32;
  endfunction

  function automatic logic [31:0] pad_c0(input int set, input int idx, input logic [31:0] w);
    int rem;
    rem = c0_bits(set) % 32;
    if (idx == c0_words(set) - 1 && rem != 0) return w & ((32'd1 << rem) - 32'd1);
    return w;
  endfunction

  task automatic model_a();
    exp_q.delete();
    for (int i = 0; i < c0_words(1); i++) exp_q.push_back({pad_c0(1, i, a_c0_mem[i]), 2'd0, 1'b0});
    for (int i = 0; i < 8; i++) exp_q.push_back({a_c1_mem[i], 2'd1, 1'b0});
    for (int i = 0; i < 8; i++) exp_q.push_back({a_k_mem[i], 2'd2, (i == 7)});
  endtask

  task automatic model_b();
    exp_q.delete();
    for (int i = 0; i < c0_words(4); i++) exp_q.push_back({pad_c0(4, i, b_c0_mem[i]), 2'd0, 1'b0});
    for (int i = 0; i < 8; i++) exp_q.push_back({b_c1_mem[i], 2'd1, 1'b0});
    for (int i = 0; i < 8; i++) exp_q.push_back({b_k_mem[i], 2'd2, (i == 7)});
  endtask

  task automatic compare_stream(input string tag, input word_t got[$]);
    check({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) check($sformatf("%s_w%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic pulse_a_start(input bit record);
    @(posedge clk);
    #1 a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    if (record) a_start_cyc = cyc;
  endtask

  task automatic wait_a_done(input int base);
    for (int i = 0; i < 600 && a_done_cnt == base; i++) @(posedge clk);
    repeat (4) @(posedge clk);
  endtask

  task automatic fill_a_pattern();
    for (int i = 0; i < 24; i++) a_c0_mem[i] = 32'hC000_0000 + 32'(i);
    for (int i = 0; i < 8; i++)  a_c1_mem[i] = 32'hC100_0000 + 32'(i);
    for (int i = 0; i < 8; i++)  a_k_mem[i]  = 32'h4B00_0000 + 32'(i);
  endtask

  task automatic run_a(input string tag, input bit check_lat);
    int base;
    a_got.delete();
    base = a_done_cnt;
    pulse_a_start(1'b1);
    wait_a_done(base);
    check({tag, "_done_pulses"}, 64'(a_done_cnt - base), 64'd1);
    check({tag, "_busy_after"}, 64'(a_busy), 64'd0);
    model_a();
    compare_stream(tag, a_got);
    if (check_lat) check({tag, "_latency"}, 64'(a_done_cyc - a_start_cyc), 64'(c0_words(1) + 18));
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_ctrl"}, 64'({a_busy, a_done, a_rd_C0, a_rd_C1, a_rd_K, a_dout_valid, a_dout_last}), 64'd0);
    check({tag, "_addr"}, 64'({a_C0_addr, a_C1_addr, a_K_addr}), 64'd0);
    check({tag, "_data"}, 64'({a_dout, a_dout_sel}), 64'd0);
  endtask

  initial begin
    int base, idle_viol;
    checks = 0; errors = 0; cyc = 0;
    a_done_cnt = 0; b_done_cnt = 0; a_mode = 0;
    a_stall_cnt = 0; a_stable_viol = 0; a_onehot_viol = 0; a_max_out = 0;
    a_start = 1'b0; b_start = 1'b0; b_dout_ready = 1'b1;

    // Reset state.
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check_a_zero("reset_a");
    check("reset_b_ctrl", 64'({b_busy, b_done, b_rd_C0, b_rd_C1, b_rd_K, b_dout_valid, b_dout_last}), 64'd0);
    check("reset_b_data", 64'({b_dout, b_dout_sel, b_C0_addr, b_C1_addr, b_K_addr}), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Idle: with no start, nothing may move.
    idle_viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (a_busy || a_rd_C0 || a_rd_C1 || a_rd_K || a_dout_valid) idle_viol++;
      if (b_busy || b_rd_C0 || b_rd_C1 || b_rd_K || b_dout_valid) idle_viol++;
    end
    check("idle_quiet", 64'(idle_viol), 64'd0);

    // Set 1, address-based patterns, sink always ready.
    fill_a_pattern();
    a_mode = 0;
    run_a("set1", 1'b1);
    if (a_got.size() == 40) check("set1_last_word", 64'({a_got[39].data, a_got[39].last}), {31'd0, 32'h4B00_0007, 1'b1});
    check("set1_onehot", 64'(a_onehot_viol), 64'd0);

    // Set 4: random contents; the padded last C0 word is all ones.
    for (int i = 0; i < 49; i++) b_c0_mem[i] = $urandom;
    for (int i = 0; i < 8; i++) begin
      b_c1_mem[i] = $urandom;
      b_k_mem[i]  = $urandom;
    end
    b_c0_mem[48] = 32'hFFFF_FFFF;
    b_got.delete();
    base = b_done_cnt;
    @(posedge clk);
    #1 b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    b_start_cyc = cyc;
    for (int i = 0; i < 600 && b_done_cnt == base; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    check("set4_done_pulses", 64'(b_done_cnt - base), 64'd1);
    model_b();
    compare_stream("set4", b_got);
    if (b_got.size() > 48) check("set4_pad_word", 64'(b_got[48].data), 64'h0000_07FF);
    check("set4_latency", 64'(b_done_cyc - b_start_cyc), 64'(c0_words(4) + 18));

    // Backpressure: ready follows 1,0,0,1.
    a_stall_cnt = 0; a_stable_viol = 0; a_max_out = 0; a_onehot_viol = 0;
    a_mode = 1;
    run_a("bp", 1'b0);
    check("bp_stalls_seen", 64'(a_stall_cnt > 0), 64'd1);
    check("bp_stable", 64'(a_stable_viol), 64'd0);
    check("bp_outstanding_le2", 64'(a_max_out <= 2), 64'd1);
    check("bp_onehot", 64'(a_onehot_viol), 64'd0);

    // Random data with random backpressure.
    for (int i = 0; i < 24; i++) a_c0_mem[i] = $urandom;
    for (int i = 0; i < 8; i++) begin
      a_c1_mem[i] = $urandom;
      a_k_mem[i]  = $urandom;
    end
    a_stable_viol = 0; a_max_out = 0;
    a_mode = 2;
    run_a("rnd", 1'b0);
    check("rnd_stable", 64'(a_stable_viol), 64'd0);
    check("rnd_outstanding_le2", 64'(a_max_out <= 2), 64'd1);

    // A second start at word 10 is ignored.
    fill_a_pattern();
    a_mode = 0;
    a_got.delete();
    base = a_done_cnt;
    pulse_a_start(1'b1);
    for (int i = 0; i < 200 && a_got.size() < 10; i++) @(posedge clk);
    pulse_a_start(1'b0);
    wait_a_done(base);
    repeat (20) @(posedge clk);
    check("restart_done_pulses", 64'(a_done_cnt - base), 64'd1);
    model_a();
    compare_stream("restart", a_got);
    check("restart_latency", 64'(a_done_cyc - a_start_cyc), 64'(c0_words(1) + 18));

    // Reset at word 20: outputs clear at once, no done, then a clean rerun.
    a_got.delete();
    base = a_done_cnt;
    pulse_a_start(1'b1);
    for (int i = 0; i < 200 && a_got.size() < 20; i++) @(posedge clk);
    check("midrst_reached_w20", 64'(a_busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check_a_zero("midrst");
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (60) @(posedge clk);
    check("midrst_no_done", 64'(a_done_cnt - base), 64'd0);
    check("midrst_idle", 64'({a_busy, a_dout_valid}), 64'd0);
    run_a("after_rst", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
